// File: rtl/urv_pkg.sv
// Shared definitions for the uRV instruction prefetch bridge: depth limit,
// Wishbone pipelined bus widths and bus FSM state encodings.
package urv_pkg;

    localparam int URV_IPF_MAX_DEPTH = 16;
    localparam int WB_ADR_W          = 32;
    localparam int WB_DAT_W          = 32;

    localparam logic [1:0] IPF_IDLE      = 2'd0;
    localparam logic [1:0] IPF_ISSUE     = 2'd1;
    localparam logic [1:0] IPF_WAIT_FULL = 2'd2;

endpackage

// File: rtl/urv_iprefetch_fifo.sv
// DEPTH x DATA_W synchronous FIFO holding prefetched instruction words;
// flush wins over a push in the same cycle.
module urv_iprefetch_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [DATA_W-1:0]      rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/urv_iprefetch.sv
// Instruction prefetch bridge: serves the uRV fetch port from a sequential
// prefetch buffer fed by a pipelined Wishbone master, dropping stale reads on jumps.
module urv_iprefetch
    import urv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [WB_ADR_W-1:0] im_addr_i,
    output logic [WB_DAT_W-1:0] im_data_o,
    output logic                im_valid_o,
    output logic                ibus_cyc_o,
    output logic                ibus_stb_o,
    output logic [WB_ADR_W-1:0] ibus_adr_o,
    input  logic                ibus_stall_i,
    input  logic                ibus_ack_i,
    input  logic [WB_DAT_W-1:0] ibus_dat_i
);
    localparam int IPF_DEPTH = (DEPTH > URV_IPF_MAX_DEPTH) ? URV_IPF_MAX_DEPTH : DEPTH;
    localparam int CNT_W     = $clog2(IPF_DEPTH) + 1;
    localparam int LVL_W     = CNT_W + 1;

    logic [1:0]          state;
    logic [WB_ADR_W-1:0] head_addr, pf_addr, last_addr;
    logic [WB_DAT_W-1:0] last_data;
    logic                last_valid, stale_stb;
    logic [CNT_W-1:0]    outstanding, discard;

    logic [WB_DAT_W-1:0] fifo_rd_data;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty, fifo_full;

    logic [WB_ADR_W-1:0] req_addr, pf_nxt;
    logic [WB_DAT_W-1:0] hit_data;
    logic [CNT_W-1:0]    out_nxt, discard_nxt, count_nxt;
    logic                accept, ack_live, ack_drop, replay, head_match, bypass;
    logic                hit, miss, push, pop, hold_stb, stb_nxt;

    urv_iprefetch_fifo #(
        .DEPTH  (IPF_DEPTH),
        .DATA_W (WB_DAT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push    (push),
        .pop     (pop),
        .flush   (miss),
        .wr_data (ibus_dat_i),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_comb begin
        req_addr   = im_addr_i & ~32'h3;
        accept     = ibus_stb_o && !ibus_stall_i;
        ack_drop   = ibus_ack_i && (discard != '0);
        ack_live   = ibus_ack_i && (discard == '0);
        replay     = last_valid && (req_addr == last_addr);
        // Nothing is tagged until the first miss after reset.
        head_match = (state != IPF_IDLE) && (req_addr == head_addr);
        bypass     = ack_live && fifo_empty;
        hit        = !replay && head_match && (!fifo_empty || bypass);
        miss       = !replay && !head_match;
        pop        = hit && !fifo_empty;
        push       = ack_live && !(hit && bypass) && (!fifo_full || pop);
        hit_data   = fifo_empty ? ibus_dat_i : fifo_rd_data;
        out_nxt    = outstanding + CNT_W'(accept) - CNT_W'(ibus_ack_i);
        hold_stb   = ibus_stb_o && ibus_stall_i;

        // On a flush every read still in flight belongs to the old stream.
        if (miss) begin
            discard_nxt = out_nxt;
            count_nxt   = '0;
            pf_nxt      = req_addr;
        end else begin
            discard_nxt = discard - CNT_W'(ack_drop) + CNT_W'(accept && stale_stb);
            count_nxt   = fifo_count + CNT_W'(push) - CNT_W'(pop);
            pf_nxt      = (accept && !stale_stb) ? pf_addr + 32'd4 : pf_addr;
        end

        stb_nxt = hold_stb ||
                  (({1'b0, count_nxt} + {1'b0, out_nxt}) < LVL_W'(IPF_DEPTH));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IPF_IDLE;
            head_addr   <= '0;
            pf_addr     <= '0;
            outstanding <= '0;
            discard     <= '0;
            stale_stb   <= 1'b0;
            last_addr   <= '0;
            last_data   <= '0;
            last_valid  <= 1'b0;
            im_data_o   <= '0;
            im_valid_o  <= 1'b0;
            ibus_cyc_o  <= 1'b0;
            ibus_stb_o  <= 1'b0;
            ibus_adr_o  <= '0;
        end else begin
            state       <= stb_nxt ? IPF_ISSUE : IPF_WAIT_FULL;
            outstanding <= out_nxt;
            discard     <= discard_nxt;
            pf_addr     <= pf_nxt;
            // A strobe stuck under stall across a flush is counted stale when accepted.
            stale_stb   <= hold_stb && (stale_stb || miss);
            ibus_stb_o  <= stb_nxt;
            ibus_cyc_o  <= stb_nxt || (out_nxt != '0);
            if (!hold_stb)
                ibus_adr_o <= pf_nxt;

            im_valid_o <= replay || hit;
            if (hit)
                im_data_o <= hit_data;
            else if (replay)
                im_data_o <= last_data;

            if (hit) begin
                head_addr  <= head_addr + 32'd4;
                last_addr  <= req_addr;
                last_data  <= hit_data;
                last_valid <= 1'b1;
            end else if (miss) begin
                head_addr  <= req_addr;
                last_valid <= 1'b0;
            end
        end
    end

endmodule
